cyclic_block_decoder: RTL and testbench

CYCLIC_BLOCK_DECODER -- requirements
Module: cyclic_block_decoder

---
 rtl/bch_dec_pkg.sv | 39 +++
 rtl/bch_syndrome_lfsr.sv | 34 +++
 rtl/cyclic_block_decoder.sv | 159 +++++++++++++++
 tb/tb_cyclic_block_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_dec_pkg.sv
// Shared types and the elaboration-time syndrome table builder for the cyclic block decoder.
package bch_dec_pkg;

  localparam int MAX_R = 8;
  localparam int MAX_K = 16;

  typedef struct packed {
    logic             correctable;
    logic [MAX_K-1:0] pattern;
  } syn_entry_t;

  typedef syn_entry_t [2**MAX_R-1:0] syn_table_t;

  // Each single-bit error x^i maps to the remainder x^i mod g; errors in parity positions
  // are still correctable but leave the data bits untouched (all-zero pattern).
  function automatic syn_table_t buildSyndromeTable(input logic [MAX_R:0] poly,
                                                    input int n, input int k);
    syn_table_t       tbl;
    syn_entry_t       entry;
    logic [MAX_R:0]   rem;
    logic [MAX_R-1:0] syn;
    logic [MAX_R-1:0] mask;
    int               r;
    r    = n - k;
    tbl  = '0;
    rem  = {{MAX_R{1'b0}}, 1'b1};
    mask = MAX_R'((1 << r) - 1);
    for (int i = 0; i < n; i++) begin
      syn               = rem[MAX_R-1:0] & mask;
      entry.correctable = 1'b1;
      entry.pattern     = (i >= r) ? (MAX_K'(1) << (i - r)) : '0;
      tbl[syn]          = entry;
      rem               = rem << 1;
      if (rem[r]) rem = rem ^ poly;
    end
    return tbl;
  endfunction

endpackage

// File: rtl/bch_syndrome_lfsr.sv
// Serial polynomial-division LFSR: remainder of the received bit stream (MSB first) mod POLY.
module bch_syndrome_lfsr #(
  parameter int              DEGREE = 3,
  parameter logic [DEGREE:0] POLY   = 4'b1011
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic              i_bit,
  output logic [DEGREE-1:0] o_remainder,
  output logic [DEGREE-1:0] o_remainderNext
);

  logic [DEGREE-1:0] r_rem;
  logic [DEGREE-1:0] w_next;

  assign w_next = {r_rem[DEGREE-2:0], i_bit} ^ ({DEGREE{r_rem[DEGREE-1]}} & POLY[DEGREE-1:0]);

  // Clear takes priority so a finished block can hand off while the next one starts from zero.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rem <= '0;
    end else if (i_clear) begin
      r_rem <= '0;
    end else if (i_shift) begin
      r_rem <= w_next;
    end
  end

  assign o_remainder     = r_rem;
  assign o_remainderNext = w_next;

endmodule

// File: rtl/cyclic_block_decoder.sv
// Serial cyclic block decoder: collect (A) -> hold (B) -> output (C) pipeline that streams out
// the K data bits of each codeword, optionally corrected through a single-error syndrome table.
module cyclic_block_decoder
  import bch_dec_pkg::*;
#(
  parameter     DEC_BCH_POLYNOM = 4'b1011,
  parameter int DEC_N           = 7,
  parameter int DEC_K           = 4,
  parameter bit CORRECT_EN      = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic DATA_IN,
  input  logic DATA_IN_VALID,
  output logic DATA_IN_READY,
  output logic DATA_OUT,
  output logic DATA_OUT_VALID,
  input  logic DATA_OUT_READY,
  output logic DATA_OUT_LAST,
  output logic ERR_DETECTED,
  output logic ERR_CORRECTED,
  output logic UNCORRECTABLE
);

  localparam int              R         = DEC_N - DEC_K;
  localparam int              PW        = MAX_R + 1;
  localparam int              AW        = $clog2(DEC_N);
  localparam int              CW        = (DEC_K > 1) ? $clog2(DEC_K) : 1;
  localparam logic [MAX_R:0]  POLY_EXT  = PW'(DEC_BCH_POLYNOM);
  localparam logic [R:0]      POLY      = POLY_EXT[R:0];
  localparam logic [AW-1:0]   A_LAST    = AW'(DEC_N - 1);
  localparam logic [CW-1:0]   C_LAST    = CW'(DEC_K - 1);
  localparam syn_table_t      SYN_TABLE = buildSyndromeTable(POLY_EXT, DEC_N, DEC_K);

  logic [DEC_N-1:0] r_aShift;
  logic [AW-1:0]    r_aCount;
  logic             r_aFull;
  logic [DEC_K-1:0] r_bData;
  logic [R-1:0]     r_bSyn;
  logic             r_bFull;
  logic [DEC_K-1:0] r_cData;
  logic [CW-1:0]    r_cCount;
  logic             r_cFull;
  logic             r_errDet;
  logic             r_errCorr;
  logic             r_uncorr;

  logic             w_inXfer;
  logic             w_aLastBit;
  logic             w_aDone;
  logic             w_aToB;
  logic [DEC_K-1:0] w_aData;
  logic [R-1:0]     w_aSyn;
  logic [R-1:0]     w_rem;
  logic [R-1:0]     w_remNext;
  logic             w_outXfer;
  logic             w_cLastBit;
  logic             w_bToC;
  logic [MAX_R-1:0] w_synIdx;
  logic             w_errDet;
  logic             w_correctable;
  logic [DEC_K-1:0] w_pattern;
  logic [DEC_K-1:0] w_corrData;

  bch_syndrome_lfsr #(
    .DEGREE (R),
    .POLY   (POLY)
  ) u_lfsr (
    .i_clock         (CLK),
    .i_reset         (RESET),
    .i_clear         (w_aToB),
    .i_shift         (w_inXfer),
    .i_bit           (DATA_IN),
    .o_remainder     (w_rem),
    .o_remainderNext (w_remNext)
  );

  // A hands off either its held block or the one completing on this very edge.
  assign w_inXfer   = DATA_IN_VALID & ~r_aFull;
  assign w_aLastBit = (r_aCount == A_LAST);
  assign w_aDone    = r_aFull | (w_inXfer & w_aLastBit);
  assign w_aData    = r_aFull ? r_aShift[DEC_N-1:R] : r_aShift[DEC_N-2:R-1];
  assign w_aSyn     = r_aFull ? w_rem : w_remNext;
  assign w_aToB     = w_aDone & (~r_bFull | w_bToC);

  assign w_outXfer  = r_cFull & DATA_OUT_READY;
  assign w_cLastBit = (r_cCount == C_LAST);
  assign w_bToC     = r_bFull & (~r_cFull | (w_outXfer & w_cLastBit));

  assign w_synIdx      = MAX_R'(r_bSyn);
  assign w_errDet      = |r_bSyn;
  assign w_correctable = SYN_TABLE[w_synIdx].correctable;
  assign w_pattern     = CORRECT_EN ? SYN_TABLE[w_synIdx].pattern[DEC_K-1:0] : '0;
  assign w_corrData    = r_bData ^ w_pattern;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_aShift <= '0;
      r_aCount <= '0;
      r_aFull  <= 1'b0;
    end else begin
      if (w_inXfer) begin
        r_aShift <= {r_aShift[DEC_N-2:0], DATA_IN};
        r_aCount <= w_aLastBit ? '0 : r_aCount + 1'b1;
      end
      if (w_aToB) begin
        r_aFull <= 1'b0;
      end else if (w_inXfer & w_aLastBit) begin
        r_aFull <= 1'b1;
      end
    end
  end

  // Only the data bits travel on; the parity bits are fully summarised by the syndrome.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bData <= '0;
      r_bSyn  <= '0;
      r_bFull <= 1'b0;
    end else if (w_aToB) begin
      r_bData <= w_aData;
      r_bSyn  <= w_aSyn;
      r_bFull <= 1'b1;
    end else if (w_bToC) begin
      r_bFull <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cData   <= '0;
      r_cCount  <= '0;
      r_cFull   <= 1'b0;
      r_errDet  <= 1'b0;
      r_errCorr <= 1'b0;
      r_uncorr  <= 1'b0;
    end else if (w_bToC) begin
      r_cData   <= w_corrData;
      r_cCount  <= '0;
      r_cFull   <= 1'b1;
      r_errDet  <= w_errDet;
      r_errCorr <= w_errDet & w_correctable & CORRECT_EN;
      r_uncorr  <= w_errDet & ~w_correctable;
    end else if (w_outXfer) begin
      r_cData  <= {r_cData[DEC_K-2:0], 1'b0};
      r_cCount <= r_cCount + 1'b1;
      if (w_cLastBit) r_cFull <= 1'b0;
    end
  end

  assign DATA_IN_READY  = ~r_aFull;
  assign DATA_OUT       = r_cFull & r_cData[DEC_K-1];
  assign DATA_OUT_VALID = r_cFull;
  assign DATA_OUT_LAST  = r_cFull & w_cLastBit;
  assign ERR_DETECTED   = r_cFull & r_errDet;
  assign ERR_CORRECTED  = r_cFull & r_errCorr;
  assign UNCORRECTABLE  = r_cFull & r_uncorr;

endmodule

// File: tb/tb_cyclic_block_decoder.sv
// Directed bench: three decoder instances ((7,4) correcting, (7,4) detect-only, (15,7) BCH).
module tb_cyclic_block_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dinBit;
  logic [2:0] dinValid;
  logic [2:0] doutReady;
  logic [2:0] inReady;
  logic [2:0] dout;
  logic [2:0] doutValid;
  logic [2:0] doutLast;
  logic [2:0] errDet;
  logic [2:0] errCorr;
  logic [2:0] uncorr;
  int         testsRun    = 0;
  int         testsFailed = 0;

  always #5 clk = ~clk;

  cyclic_block_decoder #(
    .DEC_BCH_POLYNOM (4'b1011), .DEC_N (7), .DEC_K (4), .CORRECT_EN (1'b1)
  ) dutCorr (
    .CLK (clk), .RESET (rst), .DATA_IN (dinBit[0]), .DATA_IN_VALID (dinValid[0]),
    .DATA_IN_READY (inReady[0]), .DATA_OUT (dout[0]), .DATA_OUT_VALID (doutValid[0]),
    .DATA_OUT_READY (doutReady[0]), .DATA_OUT_LAST (doutLast[0]), .ERR_DETECTED (errDet[0]),
    .ERR_CORRECTED (errCorr[0]), .UNCORRECTABLE (uncorr[0])
  );

  cyclic_block_decoder #(
    .DEC_BCH_POLYNOM (4'b1011), .DEC_N (7), .DEC_K (4), .CORRECT_EN (1'b0)
  ) dutDetect (
    .CLK (clk), .RESET (rst), .DATA_IN (dinBit[1]), .DATA_IN_VALID (dinValid[1]),
    .DATA_IN_READY (inReady[1]), .DATA_OUT (dout[1]), .DATA_OUT_VALID (doutValid[1]),
    .DATA_OUT_READY (doutReady[1]), .DATA_OUT_LAST (doutLast[1]), .ERR_DETECTED (errDet[1]),
    .ERR_CORRECTED (errCorr[1]), .UNCORRECTABLE (uncorr[1])
  );

  cyclic_block_decoder #(
    .DEC_BCH_POLYNOM (9'b111010001), .DEC_N (15), .DEC_K (7), .CORRECT_EN (1'b1)
  ) dutBch (
    .CLK (clk), .RESET (rst), .DATA_IN (dinBit[2]), .DATA_IN_VALID (dinValid[2]),
    .DATA_IN_READY (inReady[2]), .DATA_OUT (dout[2]), .DATA_OUT_VALID (doutValid[2]),
    .DATA_OUT_READY (doutReady[2]), .DATA_OUT_LAST (doutLast[2]), .ERR_DETECTED (errDet[2]),
    .ERR_CORRECTED (errCorr[2]), .UNCORRECTABLE (uncorr[2])
  );

  // Drives word[n-1:0] MSB first starting at a falling edge; each bit transfers on the next
  // rising edge once ready is seen. Returns how many cycles the sender had to wait.
  task automatic sendBlock(input int d, input logic [14:0] word, input int n, output int stalls);
    stalls = 0;
    for (int i = n - 1; i >= 0; i--) begin
      dinValid[d] = 1'b1;
      dinBit[d]   = word[i];
      while (!inReady[d] && stalls < 200) begin
        @(negedge clk);
        stalls++;
      end
      if (!inReady[d]) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL send_timeout: dut %0d bit %0d got ready=0 after 200 cycles, expected ready=1", d, i);
        dinValid[d] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    dinValid[d] = 1'b0;
  endtask

  // Records k output transfers (bit plus flags, first bit ends up most significant).
  task automatic recvBlock(input int d, input int k, output logic [14:0] data,
                           output logic [14:0] last, output logic [14:0] det,
                           output logic [14:0] corr, output logic [14:0] unc,
                           output int waitFirst);
    int got   = 0;
    int guard = 0;
    data = '0; last = '0; det = '0; corr = '0; unc = '0;
    waitFirst = -1;
    while (got < k && guard < 300) begin
      if (doutValid[d] && doutReady[d]) begin
        if (got == 0) waitFirst = guard;
        data = {data[13:0], dout[d]};
        last = {last[13:0], doutLast[d]};
        det  = {det[13:0], errDet[d]};
        corr = {corr[13:0], errCorr[d]};
        unc  = {unc[13:0], uncorr[d]};
        got++;
      end
      @(negedge clk);
      guard++;
    end
    if (got < k) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL recv_timeout: dut %0d got %0d bits, expected %0d", d, got, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dinBit = '0; dinValid = '0; doutReady = '0;
    repeat (3) @(negedge clk);
    testsRun++; if (dout !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_dout: got %b, expected 000", dout); end
    testsRun++; if (doutValid !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b, expected 000", doutValid); end
    testsRun++; if (doutLast !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_last: got %b, expected 000", doutLast); end
    testsRun++; if (errDet !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_errdet: got %b, expected 000", errDet); end
    testsRun++; if (errCorr !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_errcorr: got %b, expected 000", errCorr); end
    testsRun++; if (uncorr !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_uncorr: got %b, expected 000", uncorr); end
    rst = 1'b0;
    @(negedge clk);
    testsRun++; if (inReady !== 3'b111) begin testsFailed++; $display("[TB] FAIL reset_inready: got %b, expected 111", inReady); end
  endtask

  task automatic test_clean();
    logic [14:0] data, last, det, corr, unc;
    int waitFirst, stalls;
    @(negedge clk);
    doutReady[0] = 1'b1;
    sendBlock(0, 15'b1000101, 7, stalls);
    testsRun++; if (doutValid[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL clean_early_valid: got %b, expected 0", doutValid[0]); end
    recvBlock(0, 4, data, last, det, corr, unc, waitFirst);
    testsRun++; if (waitFirst !== 1) begin testsFailed++; $display("[TB] FAIL clean_latency: got %0d, expected 1", waitFirst); end
    testsRun++; if (data[3:0] !== 4'b1000) begin testsFailed++; $display("[TB] FAIL clean_data: got %b, expected 1000", data[3:0]); end
    testsRun++; if (last[3:0] !== 4'b0001) begin testsFailed++; $display("[TB] FAIL clean_last: got %b, expected 0001", last[3:0]); end
    testsRun++; if ({det[3:0], corr[3:0], unc[3:0]} !== 12'h000) begin testsFailed++; $display("[TB] FAIL clean_flags: got %h, expected 000", {det[3:0], corr[3:0], unc[3:0]}); end
  endtask

  task automatic test_correct();
    logic [14:0] data, last, det, corr, unc;
    int waitFirst, stalls;
    @(negedge clk);
    doutReady[0] = 1'b1;
    sendBlock(0, 15'b0000101, 7, stalls);
    recvBlock(0, 4, data, last, det, corr, unc, waitFirst);
    testsRun++; if (data[3:0] !== 4'b1000) begin testsFailed++; $display("[TB] FAIL correct_data: got %b, expected 1000", data[3:0]); end
    testsRun++; if (det[3:0] !== 4'b1111) begin testsFailed++; $display("[TB] FAIL correct_errdet: got %b, expected 1111", det[3:0]); end
    testsRun++; if (corr[3:0] !== 4'b1111) begin testsFailed++; $display("[TB] FAIL correct_errcorr: got %b, expected 1111", corr[3:0]); end
    testsRun++; if (unc[3:0] !== 4'b0000) begin testsFailed++; $display("[TB] FAIL correct_uncorr: got %b, expected 0000", unc[3:0]); end
  endtask

  task automatic test_parity_error();
    logic [14:0] data, last, det, corr, unc;
    int waitFirst, stalls;
    @(negedge clk);
    doutReady[0] = 1'b1;
    sendBlock(0, 15'b1000100, 7, stalls);
    recvBlock(0, 4, data, last, det, corr, unc, waitFirst);
    testsRun++; if (data[3:0] !== 4'b1000) begin testsFailed++; $display("[TB] FAIL parity_data: got %b, expected 1000", data[3:0]); end
    testsRun++; if ({det[3:0], corr[3:0], unc[3:0]} !== 12'hFF0) begin testsFailed++; $display("[TB] FAIL parity_flags: got %h, expected ff0", {det[3:0], corr[3:0], unc[3:0]}); end
  endtask

  task automatic test_detect_only();
    logic [14:0] data, last, det, corr, unc;
    int waitFirst, stalls;
    @(negedge clk);
    doutReady[1] = 1'b1;
    sendBlock(1, 15'b0000101, 7, stalls);
    recvBlock(1, 4, data, last, det, corr, unc, waitFirst);
    testsRun++; if (data[3:0] !== 4'b0000) begin testsFailed++; $display("[TB] FAIL detect_data: got %b, expected 0000", data[3:0]); end
    testsRun++; if (det[3:0] !== 4'b1111) begin testsFailed++; $display("[TB] FAIL detect_errdet: got %b, expected 1111", det[3:0]); end
    testsRun++; if (corr[3:0] !== 4'b0000) begin testsFailed++; $display("[TB] FAIL detect_errcorr: got %b, expected 0000", corr[3:0]); end
    testsRun++; if (unc[3:0] !== 4'b0000) begin testsFailed++; $display("[TB] FAIL detect_uncorr: got %b, expected 0000", unc[3:0]); end
  endtask

  task automatic test_uncorrectable();
    logic [14:0] data, last, det, corr, unc;
    int waitFirst, stalls;
    @(negedge clk);
    doutReady[2] = 1'b1;
    sendBlock(2, 15'b110000000000000, 15, stalls);
    recvBlock(2, 7, data, last, det, corr, unc, waitFirst);
    testsRun++; if (data[6:0] !== 7'b1100000) begin testsFailed++; $display("[TB] FAIL bch_double_data: got %b, expected 1100000", data[6:0]); end
    testsRun++; if (last[6:0] !== 7'b0000001) begin testsFailed++; $display("[TB] FAIL bch_double_last: got %b, expected 0000001", last[6:0]); end
    testsRun++; if (det[6:0] !== 7'b1111111) begin testsFailed++; $display("[TB] FAIL bch_double_errdet: got %b, expected 1111111", det[6:0]); end
    testsRun++; if (unc[6:0] !== 7'b1111111) begin testsFailed++; $display("[TB] FAIL bch_double_uncorr: got %b, expected 1111111", unc[6:0]); end
    testsRun++; if (corr[6:0] !== 7'b0000000) begin testsFailed++; $display("[TB] FAIL bch_double_errcorr: got %b, expected 0000000", corr[6:0]); end
  endtask

  task automatic test_bch_single();
    logic [14:0] data, last, det, corr, unc;
    int waitFirst, stalls;
    @(negedge clk);
    doutReady[2] = 1'b1;
    sendBlock(2, 15'b100000000000000, 15, stalls);
    recvBlock(2, 7, data, last, det, corr, unc, waitFirst);
    testsRun++; if (data[6:0] !== 7'b0000000) begin testsFailed++; $display("[TB] FAIL bch_single_data: got %b, expected 0000000", data[6:0]); end
    testsRun++; if ({corr[6:0], unc[6:0]} !== 14'b1111111_0000000) begin testsFailed++; $display("[TB] FAIL bch_single_flags: got %b, expected 11111110000000", {corr[6:0], unc[6:0]}); end
  endtask

  task automatic test_back_to_back();
    logic [14:0] data, last, det, corr, unc;
    logic [15:0] allData, allLast, allDet;
    int waitFirst, s1, s2, s3, s4;
    allData = '0; allLast = '0; allDet = '0;
    @(negedge clk);
    doutReady[0] = 1'b0;
    sendBlock(0, 15'b1000101, 7, s1);
    sendBlock(0, 15'b0100111, 7, s2);
    sendBlock(0, 15'b0010110, 7, s3);
    testsRun++; if (s1 + s2 + s3 !== 0) begin testsFailed++; $display("[TB] FAIL b2b_input_stalls: got %0d, expected 0", s1 + s2 + s3); end
    testsRun++; if (inReady[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_ready_falls: got %b, expected 0", inReady[0]); end
    repeat (20) @(negedge clk);
    testsRun++; if (inReady[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_ready_held: got %b, expected 0", inReady[0]); end
    testsRun++; if ({doutValid[0], dout[0], doutLast[0]} !== 3'b110) begin testsFailed++; $display("[TB] FAIL b2b_stall_hold: got %b, expected 110", {doutValid[0], dout[0], doutLast[0]}); end
    doutReady[0] = 1'b1;
    fork
      sendBlock(0, 15'b0101011, 7, s4);
      begin
        for (int b = 0; b < 4; b++) begin
          recvBlock(0, 4, data, last, det, corr, unc, waitFirst);
          allData = {allData[11:0], data[3:0]};
          allLast = {allLast[11:0], last[3:0]};
          allDet  = {allDet[11:0], det[3:0]};
        end
      end
    join
    testsRun++; if (allData !== 16'h8421) begin testsFailed++; $display("[TB] FAIL b2b_data: got %h, expected 8421", allData); end
    testsRun++; if (allLast !== 16'h1111) begin testsFailed++; $display("[TB] FAIL b2b_last: got %h, expected 1111", allLast); end
    testsRun++; if (allDet !== 16'h000F) begin testsFailed++; $display("[TB] FAIL b2b_errdet: got %h, expected 000f", allDet); end
    repeat (10) @(negedge clk);
    testsRun++; if (doutValid[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_no_extra: got %b, expected 0", doutValid[0]); end
  endtask

  task automatic test_reset_mid();
    logic [14:0] data, last, det, corr, unc;
    int waitFirst, stalls;
    @(negedge clk);
    doutReady[0] = 1'b0;
    sendBlock(0, 15'b1000101, 7, stalls);
    sendBlock(0, 15'b100, 3, stalls);
    testsRun++; if (doutValid[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_pre_valid: got %b, expected 1", doutValid[0]); end
    #2 rst = 1'b1;
    #1;
    testsRun++; if ({doutValid[0], dout[0], doutLast[0], errDet[0]} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL midrst_outputs: got %b, expected 0000", {doutValid[0], dout[0], doutLast[0], errDet[0]}); end
    @(negedge clk);
    rst = 1'b0;
    testsRun++; if (inReady[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_inready: got %b, expected 1", inReady[0]); end
    doutReady[0] = 1'b1;
    sendBlock(0, 15'b1000101, 7, stalls);
    recvBlock(0, 4, data, last, det, corr, unc, waitFirst);
    testsRun++; if (data[3:0] !== 4'b1000) begin testsFailed++; $display("[TB] FAIL midrst_data: got %b, expected 1000", data[3:0]); end
    testsRun++; if ({last[3:0], det[3:0]} !== 8'b0001_0000) begin testsFailed++; $display("[TB] FAIL midrst_flags: got %b, expected 00010000", {last[3:0], det[3:0]}); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_clean();
    test_correct();
    test_parity_error();
    test_detect_only();
    test_uncorrectable();
    test_bch_single();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
